// File: rtl/adc_dac_feed_if.sv
// Word-stream input and sample/DAC output bundle for adc_dac_feed.
interface adc_dac_feed_if;
    logic [15:0] adcdata;
    logic        wrreq;
    logic [23:0] sample_out;
    logic [7:0]  status_out;
    logic        sample_valid;
    logic [13:0] dac_data;
    logic        dac_valid;
    logic        frame_err;

    modport master (
        output adcdata, wrreq,
        input  sample_out, status_out, sample_valid, dac_data, dac_valid, frame_err
    );

    modport slave (
        input  adcdata, wrreq,
        output sample_out, status_out, sample_valid, dac_data, dac_valid, frame_err
    );
endinterface

// File: rtl/adc_dac_feed.sv
// Pairs 16-bit AD7760 words into 24-bit samples + status, block-averages
// 2^DEC_LOG2 samples and drives a 14-bit offset-binary DAC word.
module adc_dac_feed #(
    parameter int unsigned DEC_LOG2     = 2,
    parameter int unsigned WORD_TIMEOUT = 16
) (
    input logic           mclk,
    input logic           rest,
    adc_dac_feed_if.slave bus
);
    localparam int unsigned SW = 24;
    localparam int unsigned AW = SW + DEC_LOG2;
    localparam int unsigned CW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
    localparam int unsigned TW = 8;
    localparam int unsigned DW = 14;
    localparam logic [TW-1:0] TMAX  = TW'(WORD_TIMEOUT);
    localparam logic [CW-1:0] CLAST = CW'((1 << DEC_LOG2) - 1);
    localparam logic [DW-1:0] DAC_MID = 14'h2000;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     hi_q, hi_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   scnt_q, scnt_d;
    logic [SW-1:0]   sample_q, sample_d;
    logic [7:0]      status_q, status_d;
    logic [DW-1:0]   dac_q, dac_d;
    logic            sv_q, sv_d;
    logic            dv_q, dv_d;
    logic            fe_q, fe_d;

    logic            take;
    logic [SW-1:0]   new_sample;
    logic [AW-1:0]   sum;
    logic [DW-1:0]   avg_top;

    // Pairing FSM and block averager next-state logic.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        tcnt_d     = tcnt_q;
        acc_d      = acc_q;
        scnt_d     = scnt_q;
        sample_d   = sample_q;
        status_d   = status_q;
        dac_d      = dac_q;
        sv_d       = 1'b0;
        dv_d       = 1'b0;
        fe_d       = 1'b0;
        take       = 1'b0;
        new_sample = {hi_q, bus.adcdata[15:8]};

        unique case (state_q)
            WAIT_HI: begin
                if (bus.wrreq) begin
                    hi_d    = bus.adcdata;
                    tcnt_d  = '0;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (bus.wrreq) begin
                    take     = 1'b1;
                    sample_d = new_sample;
                    status_d = bus.adcdata[7:0];
                    sv_d     = 1'b1;
                    state_d  = WAIT_HI;
                end else if (tcnt_q == TMAX) begin
                    fe_d    = 1'b1;
                    hi_d    = '0;
                    tcnt_d  = '0;
                    state_d = WAIT_HI;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = WAIT_HI;
        endcase

        // Accumulator is wide enough for the whole block, so the sum never wraps.
        sum     = acc_q + AW'($signed(new_sample));
        avg_top = DW'($signed(sum) >>> (DEC_LOG2 + 10));

        if (take) begin
            if (scnt_q == CLAST) begin
                dac_d  = {~avg_top[DW-1], avg_top[DW-2:0]};
                dv_d   = 1'b1;
                acc_d  = '0;
                scnt_d = '0;
            end else begin
                acc_d  = sum;
                scnt_d = scnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rest) begin
            state_q  <= WAIT_HI;
            hi_q     <= '0;
            tcnt_q   <= '0;
            acc_q    <= '0;
            scnt_q   <= '0;
            sample_q <= '0;
            status_q <= '0;
            dac_q    <= DAC_MID;
            sv_q     <= 1'b0;
            dv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            tcnt_q   <= tcnt_d;
            acc_q    <= acc_d;
            scnt_q   <= scnt_d;
            sample_q <= sample_d;
            status_q <= status_d;
            dac_q    <= dac_d;
            sv_q     <= sv_d;
            dv_q     <= dv_d;
            fe_q     <= fe_d;
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.status_out   = status_q;
    assign bus.sample_valid = sv_q;
    assign bus.dac_data     = dac_q;
    assign bus.dac_valid    = dv_q;
    assign bus.frame_err    = fe_q;
endmodule
